// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned DEFAULT_DEPTH   = 32;
    localparam int unsigned DEFAULT_LATENCY = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word array with a registered read port.
// Contents are not reset; only the read register is.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Word write on strobe; storage has no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Read register captures the addressed word on the read strobe.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Holds the pipeline for LATENCY cycles, then performs the access and
// pulses ack_o for one cycle. Define DMEM_MISALIGN_ERR_EN to suppress
// misaligned accesses and flag them on err_o.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              ack_o,
    output logic [WORD_W-1:0] data_o,
`ifdef DMEM_MISALIGN_ERR_EN
    output logic              err_o,
`endif
    output logic              stall_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               misalign_c;
    logic               mem_we_c;
    logic               mem_re_c;
    logic               unused_addr_bits;

`ifdef DMEM_MISALIGN_ERR_EN
    logic [1:0]         off_q, off_d;

    // Byte offset of the latched request decides whether the access is suppressed.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            off_q <= 2'b00;
        end else begin
            off_q <= off_d;
        end
    end

    assign misalign_c = (off_q != 2'b00);
    assign off_d      = (state_q == ST_IDLE && req_i) ? addr_i[1:0] : off_q;
    assign err_o      = err_q;
`else
    assign misalign_c = 1'b0;
`endif

    // Address bits outside the word index never influence the access.
    assign unused_addr_bits = ^{addr_i[31:2+IDX_W], addr_i[1:0]};

    // State, counter, latched request and response flags.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Next-state, latency countdown and access strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        mem_we_c = 1'b0;
        mem_re_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    idx_d   = addr_i[2 +: IDX_W];
                    wdata_d = data_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    mem_we_c = we_q && !misalign_c;
                    mem_re_c = !we_q && !misalign_c;
                    ack_d    = 1'b1;
                    err_d    = misalign_c;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                // req_i here still belongs to the completed access.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stall is combinational so the CPU freezes in the request cycle itself.
    assign stall_o = ((state_q == ST_IDLE) && req_i) || (state_q == ST_BUSY);
    assign ack_o   = ack_q;

    // A reset landing on the access cycle must not commit the write.
    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_i),
        .we_i    (mem_we_c && rst_i),
        .re_i    (mem_re_c),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (data_o)
    );

endmodule
